md_unit: RTL
============

# md_unit

Iterative multiply/divide unit that is the write side of the HI/LO register pair. It sits beside the EX stage and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from EX. It computes multiply and divide results over 32 cycles while stalling the pipeline, then drives one-cycle write-enable pulses with HI/LO data into the HI/LO register file.

## Interface
Parameters:
- none. Width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  EX presents a valid md operation this cycle.
- op  in  3  operation code, from the shared defines.
- src_a  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- src_b  in  32  rt operand: multiplier or divisor.
- cancel  in  1  pipeline flush; aborts any operation in flight.
- stall_req  out  1  combinational; holds EX while a mul/div is unfinished.
- hi_we  out  1  registered write enable for HI.
- hi_o  out  32  registered HI write data.
- lo_we  out  1  registered write enable for LO.
- lo_o  out  32  registered LO write data.

## Operation
- States: IDLE, CALC, DONE. The state is held in a 2-bit register. A 5-bit iteration counter `cnt` runs alongside it.
- IDLE, start with op MTHI: on the next edge, hi_o=src_a and hi_we=1 for one cycle. lo_we stays 0. No stall.
- IDLE, start with op MTLO: the same behaviour using LO.
- IDLE, start with op MULT/MULTU/DIV/DIVU:
  - latch the operands;
  - for signed ops, store the absolute values and record the result signs;
  - clear cnt and go to CALC;
  - stall_req=1 in this same cycle.
- CALC, multiply: one radix-2 shift-add step per cycle into a 64-bit accumulator.
- CALC, divide: one restoring shift-subtract step per cycle, using a 33-bit partial remainder.
- CALC exit: after the step with cnt=31, go to DONE. stall_req=1 throughout CALC.
- DONE:
  - apply sign correction. A signed product is negated if the operand signs differ. A quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - register hi_o/lo_o. For multiply, HI is the upper 32 bits and LO the lower 32 bits. For divide, HI is the remainder and LO the quotient.
  - pulse hi_we=lo_we=1 on the next edge;
  - stall_req=0, so EX advances;
  - return to IDLE.
- start is ignored outside IDLE. EX guarantees that start stays asserted while stalled.
- Divide by zero, signed or unsigned: lo_o=32'hFFFF_FFFF and hi_o=src_a. No sign correction is applied and no exception is raised.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: lo_o=0x8000_0000, hi_o=0.
- cancel:
  - in CALC or DONE, go to IDLE on the next edge and write nothing;
  - in IDLE, suppress acceptance of a same-cycle start;
  - cancel has priority over DONE's write.
- Unknown op codes are treated as no operation.

## Timing
- Reset values: state=IDLE, cnt=0, hi_we=lo_we=0, hi_o=lo_o=0, stall_req=0.
- Reset is asynchronous and takes effect mid-operation. There is no partial write.
- MTHI/MTLO: start accepted in cycle 0, write enable visible in cycle 1, HI/LO updated at the end of cycle 1.
- Mul/div:
  - start accepted in cycle 0 (stall_req=1);
  - CALC in cycles 1–32 (stall_req=1);
  - DONE in cycle 33 (stall_req=0);
  - hi_we/lo_we high in cycle 34, with HI/LO updated at that edge.
- Total stall: 33 cycles.
- A new start may be accepted in cycle 34. The write pulse and the new acceptance may coincide.
- Write-enable pulses are exactly one cycle long.

## Structure
- Op constants MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4 and MD_MTLO=3'd5 go into lib/defines.vh, so that decode and EX share them.
- The state encodings are local to this block.
- One sub-module, md_core, holds the iteration datapath:
  - 64-bit accumulator and 33-bit remainder registers;
  - the per-step shift-add / shift-subtract logic, selected by a mode bit.
- md_unit holds the FSM, the operand conditioning, the sign correction and the output registers.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → in cycle 34, hi_we=lo_we=1 with hi_o=0xFFFF_FFFE and lo_o=0x0000_0001. stall_req is high for cycles 0–32.
- MULT −3 × 5 → hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFF1.
- DIV −7 / 2 → lo_o=0xFFFF_FFFD and hi_o=0xFFFF_FFFF. A follow-up DIVU 5 / 0 → lo_o=0xFFFF_FFFF, hi_o=0x0000_0005.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo_o=0x8000_0000, hi_o=0.
- MULT started, cancel in cycle 10 → state returns to IDLE, stall_req=0 in cycle 11, and no write enable at any point. A MTLO 0xA5A5_A5A5 in cycle 11 → lo_we=1 and lo_o=0xA5A5_A5A5 in cycle 12.
- MTHI 0x1234_5678 → hi_we=1 in cycle 1 only, with lo_we=0. resetn driven low in the middle of a DIVU's CALC → all outputs become 0 immediately and no write occurs after release.

Source files
------------

// File: rtl/md_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_unit_pkg                                                   |
// | Purpose  : Shared multiply/divide op codes and sign helper functions.    |
// |            The op codes are the values that decode and EX drive on the  |
// |            md_unit op port.                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package md_unit_pkg;

   typedef logic [2:0] md_op_t;

   localparam md_op_t MD_MULT  = 3'd0;
   localparam md_op_t MD_MULTU = 3'd1;
   localparam md_op_t MD_DIV   = 3'd2;
   localparam md_op_t MD_DIVU  = 3'd3;
   localparam md_op_t MD_MTHI  = 3'd4;
   localparam md_op_t MD_MTLO  = 3'd5;

   // Two's complement negate when n is set.
   function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
      return n ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
      return n ? (~v + 64'd1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_core                                                       |
// | Purpose  : Iteration datapath of the multiply/divide unit. One radix-2   |
// |            shift-add (multiply) or restoring shift-subtract (divide)    |
// |            step per i_step cycle on unsigned operands.                   |
// | Ports    : clk, resetn   - clock, async active-low reset                 |
// |            i_load        - capture operands, clear remainder             |
// |            i_mode_div    - 1: divide, 0: multiply (sampled on i_load)    |
// |            i_a, i_b      - multiplicand/dividend, multiplier/divisor     |
// |            i_step        - perform one iteration                         |
// |            o_acc         - product (mul) / quotient in [31:0] (div)      |
// |            o_rem         - remainder (div)                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module md_core (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_load,
   input  logic        i_mode_div,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_step,
   output logic [63:0] o_acc,
   output logic [31:0] o_rem
);

   logic        r_mode_div;
   logic [31:0] r_opnd;   // multiplicand (mul) or divisor (div)
   logic [63:0] r_acc;    // {partial product, multiplier} or shifting dividend/quotient
   logic [32:0] r_rem;    // partial remainder

   logic [32:0] w_sum;
   logic [33:0] w_partial;
   logic [33:0] w_diff;

   // Multiply: add multiplicand into upper half when the current multiplier
   // bit is set, then shift the whole accumulator right by one.
   assign w_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);

   // Divide: shift next dividend bit into the remainder and try subtracting.
   // A borrow (bit 33) means restore, i.e. keep the shifted remainder.
   assign w_partial = {r_rem, r_acc[31]};
   assign w_diff    = w_partial - {2'b00, r_opnd};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mode_div <= 1'b0;
         r_opnd     <= '0;
         r_acc      <= '0;
         r_rem      <= '0;
      end else if (i_load) begin
         r_mode_div <= i_mode_div;
         r_opnd     <= i_mode_div ? i_b : i_a;
         r_acc      <= {32'd0, (i_mode_div ? i_a : i_b)};
         r_rem      <= '0;
      end else if (i_step) begin
         if (r_mode_div) begin
            if (w_diff[33]) begin
               r_rem <= w_partial[32:0];
               r_acc <= {r_acc[62:0], 1'b0};
            end else begin
               r_rem <= w_diff[32:0];
               r_acc <= {r_acc[62:0], 1'b1};
            end
         end else begin
            r_acc <= {w_sum, r_acc[31:1]};
         end
      end
   end

   assign o_acc = r_acc;
   assign o_rem = r_rem[31:0];

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : md_unit                                                       |
// | Purpose  : Iterative multiply/divide unit, write side of HI/LO. Accepts  |
// |            MULT/MULTU/DIV/DIVU (33-cycle stall) and MTHI/MTLO (no stall) |
// |            and emits one-cycle HI/LO write pulses.                       |
// | Ports    : clk, resetn   - clock, async active-low reset                 |
// |            start, op     - operation request from EX                     |
// |            src_a, src_b  - rs / rt operands                              |
// |            cancel        - pipeline flush, aborts work in flight         |
// |            stall_req     - combinational EX hold                         |
// |            hi_we, hi_o   - registered HI write enable / data             |
// |            lo_we, lo_o   - registered LO write enable / data             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module md_unit
   import md_unit_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   output logic        stall_req,
   output logic        hi_we,
   output logic [31:0] hi_o,
   output logic        lo_we,
   output logic [31:0] lo_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [4:0] C_LAST_STEP = 5'd31;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [4:0]  r_cnt;

   // Latched operation attributes
   logic        r_is_div;
   logic        r_neg_prod;
   logic        r_neg_quot;
   logic        r_neg_rem;
   logic        r_div0;
   logic [31:0] r_a_raw;

   // Decode
   logic        w_op_md;
   logic        w_op_signed;
   logic        w_op_div;
   logic        w_sign_a;
   logic        w_sign_b;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;

   // FSM outputs
   logic        w_accept_md;
   logic        w_accept_mthi;
   logic        w_accept_mtlo;
   logic        w_step;
   logic        w_write;

   // Datapath results
   logic [63:0] w_acc;
   logic [31:0] w_rem;
   logic [63:0] w_prod;
   logic [31:0] w_hi_res;
   logic [31:0] w_lo_res;

   always_comb begin
      w_op_md     = 1'b0;
      w_op_signed = 1'b0;
      w_op_div    = 1'b0;
      case (op)
         MD_MULT:  begin w_op_md = 1'b1; w_op_signed = 1'b1; end
         MD_MULTU: begin w_op_md = 1'b1; end
         MD_DIV:   begin w_op_md = 1'b1; w_op_signed = 1'b1; w_op_div = 1'b1; end
         MD_DIVU:  begin w_op_md = 1'b1; w_op_div = 1'b1; end
         default:  begin w_op_md = 1'b0; end
      endcase
   end

   assign w_sign_a = w_op_signed & src_a[31];
   assign w_sign_b = w_op_signed & src_b[31];
   assign w_abs_a  = neg32(src_a, w_sign_a);
   assign w_abs_b  = neg32(src_b, w_sign_b);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept_md) w_state_nxt = ST_CALC;
         ST_CALC: begin
            if (cancel)                   w_state_nxt = ST_IDLE;
            else if (r_cnt == C_LAST_STEP) w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_accept_md   = 1'b0;
      w_accept_mthi = 1'b0;
      w_accept_mtlo = 1'b0;
      w_step        = 1'b0;
      w_write       = 1'b0;
      stall_req     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !cancel) begin
               w_accept_md   = w_op_md;
               w_accept_mthi = (op == MD_MTHI);
               w_accept_mtlo = (op == MD_MTLO);
            end
            // Held low while in reset so that outputs read all-zero.
            stall_req = w_accept_md & resetn;
         end
         ST_CALC: begin
            w_step    = 1'b1;
            stall_req = 1'b1;
         end
         ST_DONE: begin
            w_write = ~cancel;
         end
         default: begin
            stall_req = 1'b0;
         end
      endcase
   end

   // ---------------- Iteration counter ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (w_accept_md) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= r_cnt + 5'd1;
      end
   end

   // ---------------- Operand conditioning ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_is_div   <= 1'b0;
         r_neg_prod <= 1'b0;
         r_neg_quot <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div0     <= 1'b0;
         r_a_raw    <= '0;
      end else if (w_accept_md) begin
         r_is_div   <= w_op_div;
         r_neg_prod <= w_sign_a ^ w_sign_b;
         r_neg_quot <= w_sign_a ^ w_sign_b;
         r_neg_rem  <= w_sign_a;
         r_div0     <= w_op_div & (src_b == 32'd0);
         r_a_raw    <= src_a;
      end
   end

   md_core u_core (
      .clk        (clk),
      .resetn     (resetn),
      .i_load     (w_accept_md),
      .i_mode_div (w_op_div),
      .i_a        (w_abs_a),
      .i_b        (w_abs_b),
      .i_step     (w_step),
      .o_acc      (w_acc),
      .o_rem      (w_rem)
   );

   // ---------------- Sign correction ----------------
   assign w_prod = neg64(w_acc, r_neg_prod);

   always_comb begin
      w_hi_res = w_prod[63:32];
      w_lo_res = w_prod[31:0];
      if (r_is_div) begin
         if (r_div0) begin
            // Divide by zero: raw dividend to HI, all-ones quotient, no sign fix.
            w_hi_res = r_a_raw;
            w_lo_res = 32'hFFFF_FFFF;
         end else begin
            w_hi_res = neg32(w_rem, r_neg_rem);
            w_lo_res = neg32(w_acc[31:0], r_neg_quot);
         end
      end
   end

   // ---------------- Output registers ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_we <= 1'b0;
         lo_we <= 1'b0;
         hi_o  <= '0;
         lo_o  <= '0;
      end else begin
         hi_we <= 1'b0;
         lo_we <= 1'b0;
         if (w_write) begin
            hi_we <= 1'b1;
            lo_we <= 1'b1;
            hi_o  <= w_hi_res;
            lo_o  <= w_lo_res;
         end else if (w_accept_mthi) begin
            hi_we <= 1'b1;
            hi_o  <= src_a;
         end else if (w_accept_mtlo) begin
            lo_we <= 1'b1;
            lo_o  <= src_a;
         end
      end
   end

endmodule
`default_nettype wire
